writeback_buffered: RTL and testbench
=====================================

Name: writeback_buffered

Overview:
- Parametrised successor of the combinational writeback stage.
- Accepts one retiring instruction per cycle from execute and resolves the next PC into a registered redirect.
- Queues register-file writes in a DEPTH-entry FIFO that drains through a ready/valid port, so a busy regfile port no longer stalls execute directly.
- Provides NUM_BYPASS combinational forwarding lookups into the pending writes. Sits between execute and the regfile/fetch PC logic.

Parameters:
- XLEN, 64, data width of register results.
- ALEN, 64, address width of PCs and targets.
- DEPTH, 4, pending-write FIFO entries; power of two, >= 2.
- NUM_BYPASS, 2, number of forwarding lookup ports.
- RESET_PC, '0, value of next_pc after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  execute presents a retiring instruction
- in_ready  out  1  stage can accept; equals (count != DEPTH)
- exec_exception  in  1  instruction raised a synchronous exception
- exec_interrupt  in  1  interrupt taken at this instruction
- exec_trap_target  in  ALEN  trap vector
- exec_is_taken_branch  in  1  branch/jump taken
- exec_is_xret  in  1  xRET; target carried in exec_result
- exec_is_reg_write  in  1  instruction writes rd
- exec_reg_write_sel  in  5  rd index
- exec_result  in  XLEN  result / xRET target
- exec_branch_target  in  ALEN  taken-branch target
- exec_instruction_next_addr  in  ALEN  sequential PC
- rf_write_valid  out  1  FIFO head valid
- rf_write_ready  in  1  regfile port accepts head
- rf_write_sel  out  5  head rd
- rf_write_data  out  XLEN  head data
- bypass_sel  in  NUM_BYPASS*5  lookup indices
- bypass_hit  out  NUM_BYPASS  per-port hit
- bypass_data  out  NUM_BYPASS*XLEN  per-port forwarded data
- update_pc  out  1  registered one-cycle redirect pulse
- next_pc  out  ALEN  registered next PC
- count  out  $clog2(DEPTH+1)  pending-write occupancy

Behaviour:
- Reset (async, any cycle incl. mid-drain): head/tail pointers 0, count 0, all entry valids 0, update_pc 0, next_pc RESET_PC. rf_write_valid, bypass_hit therefore 0. Pending writes are discarded.
- Accept: accept = in_valid && in_ready.
- Enqueue:
  - enq = accept && exec_is_reg_write && !exec_exception && exec_reg_write_sel != 0.
  - Interrupt does NOT suppress the write.
  - Accepted non-writing instructions still update the PC but allocate nothing.
- PC: on accept, next_pc <= priority (exception||interrupt) trap_target > xret exec_result[ALEN-1:0] > taken_branch branch_target > next_addr. update_pc <= accept, so it is 1 exactly one cycle after each accept, otherwise 0. next_pc holds when not accepting.
- Drain:
  - rf_write_valid = (count != 0); sel/data from the head entry.
  - deq = rf_write_valid && rf_write_ready.
  - Writes leave in program order, one per cycle max.
- Simultaneous enq and deq: count unchanged. Full with deq: in_ready is still 0 that cycle (no same-cycle reuse). Empty with enq: entry visible at rf port next cycle (1-cycle latency, no pass-through).
- Pointers wrap modulo DEPTH; count saturates conceptually at DEPTH (enq blocked by in_ready).
- Bypass, per port i, combinational over stored valid entries only:
  - Hit when sel != 0 and it matches an entry.
  - If several match, the youngest (closest to tail) wins.
  - An entry being dequeued this cycle is still visible; an entry being enqueued this cycle is not.
  - On miss, data = 0.
- Illegal (assertions): rf_write_ready X while valid; count > DEPTH.

Decomposition:
- Shared package (params.svh): XLEN, ALEN; typedef wb_entry_t {sel[4:0], data[XLEN-1:0]}.
- One natural sub-module: wb_bypass_match, a youngest-match priority search over DEPTH entries given head pointer. It is instantiated NUM_BYPASS times.
- FIFO storage and PC register stay in the top.

Test Plan:
- Reset then 3 accepts writing x5=0x11, x6=0x22, x7=0x33 with rf_write_ready=1 -> rf writes appear cycles 1,2,3 in order; count peaks 1; update_pc pulses after each accept.
- rf_write_ready=0, 5 writing accepts -> in_ready drops after 4th (count=4); 5th held; raise ready -> one drain/cycle; 5th accepted the cycle after count becomes 3.
- Queue x5=0xA then x5=0xB, ready=0, bypass_sel[0]=5, bypass_sel[1]=0 -> hit[0]=1 data=0xB; hit[1]=0 data=0.
- Accept with exception=1, is_reg_write=1, sel=9, trap_target=0x80 -> no enqueue, next_pc=0x80; same with interrupt=1 instead -> enqueue x9 and next_pc=0x80.
- Accept xret (result=0x1234) with taken_branch=1 -> next_pc=0x1234; plain instr next_addr=0x104 -> next_pc=0x104.
- Fill 3 entries, assert rst mid-cycle -> immediately count=0, rf_write_valid=0, next_pc=RESET_PC, update_pc=0.

Source files
------------

// File: rtl/writeback_buffered_pkg.sv
// Shared widths and the pending-write entry layout for the buffered writeback stage.
package writeback_buffered_pkg;

    localparam int WB_XLEN = 64;
    localparam int WB_ALEN = 64;
    localparam int REG_SEL_W = 5;

    typedef struct packed {
        logic [REG_SEL_W-1:0] sel;
        logic [WB_XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_buffered_if.sv
// Execute-side, regfile-side and forwarding signals of the buffered writeback stage.
interface writeback_buffered_if #(
    parameter int XLEN       = 64,
    parameter int ALEN       = 64,
    parameter int DEPTH      = 4,
    parameter int NUM_BYPASS = 2
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          exec_exception;
    logic                          exec_interrupt;
    logic [ALEN-1:0]               exec_trap_target;
    logic                          exec_is_taken_branch;
    logic                          exec_is_xret;
    logic                          exec_is_reg_write;
    logic [4:0]                    exec_reg_write_sel;
    logic [XLEN-1:0]               exec_result;
    logic [ALEN-1:0]               exec_branch_target;
    logic [ALEN-1:0]               exec_instruction_next_addr;
    logic                          rf_write_valid;
    logic                          rf_write_ready;
    logic [4:0]                    rf_write_sel;
    logic [XLEN-1:0]               rf_write_data;
    logic [NUM_BYPASS*5-1:0]       bypass_sel;
    logic [NUM_BYPASS-1:0]         bypass_hit;
    logic [NUM_BYPASS*XLEN-1:0]    bypass_data;
    logic                          update_pc;
    logic [ALEN-1:0]               next_pc;
    logic [$clog2(DEPTH+1)-1:0]    count;

    modport master (
        output in_valid, exec_exception, exec_interrupt, exec_trap_target,
               exec_is_taken_branch, exec_is_xret, exec_is_reg_write,
               exec_reg_write_sel, exec_result, exec_branch_target,
               exec_instruction_next_addr, rf_write_ready, bypass_sel,
        input  in_ready, rf_write_valid, rf_write_sel, rf_write_data,
               bypass_hit, bypass_data, update_pc, next_pc, count
    );

    modport slave (
        input  in_valid, exec_exception, exec_interrupt, exec_trap_target,
               exec_is_taken_branch, exec_is_xret, exec_is_reg_write,
               exec_reg_write_sel, exec_result, exec_branch_target,
               exec_instruction_next_addr, rf_write_ready, bypass_sel,
        output in_ready, rf_write_valid, rf_write_sel, rf_write_data,
               bypass_hit, bypass_data, update_pc, next_pc, count
    );
endinterface

// File: rtl/writeback_buffered_bypass.sv
// Youngest-match forwarding search over the pending-write ring, walking from head to tail.
module wb_bypass_match
    import writeback_buffered_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic [DEPTH-1:0]                 vld,
    input  logic [DEPTH-1:0][REG_SEL_W-1:0]  sel,
    input  logic [DEPTH-1:0][XLEN-1:0]       data,
    input  logic [$clog2(DEPTH)-1:0]         head,
    input  logic [REG_SEL_W-1:0]             lookup,
    output logic                             hit,
    output logic [XLEN-1:0]                  hit_data
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Later iterations are younger, so the last match overrides older ones.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (lookup != '0 && vld[idx] && sel[idx] == lookup) begin
                hit      = 1'b1;
                hit_data = data[idx];
            end
        end
    end
endmodule

// File: rtl/writeback_buffered.sv
// Retires one instruction per cycle: registers the PC redirect and buffers regfile
// writes in a DEPTH-entry FIFO with combinational forwarding lookups.
module writeback_buffered
    import writeback_buffered_pkg::*;
#(
    parameter int XLEN                 = WB_XLEN,
    parameter int ALEN                 = WB_ALEN,
    parameter int DEPTH                = 4,
    parameter int NUM_BYPASS           = 2,
    parameter logic [ALEN-1:0] RESET_PC = '0
) (
    input logic                 clk,
    input logic                 rst,
    writeback_buffered_if.slave wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]                      head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]                      count_q, count_d;
    logic [DEPTH-1:0]                   vld_q, vld_d;
    logic [DEPTH-1:0][REG_SEL_W-1:0]    sel_q, sel_d;
    logic [DEPTH-1:0][XLEN-1:0]         data_q, data_d;
    logic                               update_pc_q, update_pc_d;
    logic [ALEN-1:0]                    next_pc_q, next_pc_d;
    logic                               in_ready, rf_valid, accept, enq, deq;

    always_comb begin
        in_ready = count_q != CW'(DEPTH);
        rf_valid = count_q != '0;
        accept   = wb.in_valid && in_ready;
        enq      = accept && wb.exec_is_reg_write && !wb.exec_exception
                   && wb.exec_reg_write_sel != '0;
        deq      = rf_valid && wb.rf_write_ready;

        head_d  = deq ? head_q + 1'b1 : head_q;
        tail_d  = enq ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CW'(enq) - CW'(deq);
        vld_d   = vld_q;
        sel_d   = sel_q;
        data_d  = data_q;
        // Clear before set: when full no enqueue can happen, so head != tail on overlap.
        if (deq) vld_d[head_q] = 1'b0;
        if (enq) begin
            vld_d[tail_q]  = 1'b1;
            sel_d[tail_q]  = wb.exec_reg_write_sel;
            data_d[tail_q] = wb.exec_result;
        end

        update_pc_d = accept;
        next_pc_d   = next_pc_q;
        if (accept) begin
            if (wb.exec_exception || wb.exec_interrupt) next_pc_d = wb.exec_trap_target;
            else if (wb.exec_is_xret)                   next_pc_d = ALEN'(wb.exec_result);
            else if (wb.exec_is_taken_branch)           next_pc_d = wb.exec_branch_target;
            else                                        next_pc_d = wb.exec_instruction_next_addr;
        end

        wb.in_ready       = in_ready;
        wb.rf_write_valid = rf_valid;
        wb.rf_write_sel   = sel_q[head_q];
        wb.rf_write_data  = data_q[head_q];
        wb.update_pc      = update_pc_q;
        wb.next_pc        = next_pc_q;
        wb.count          = count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            vld_q       <= '0;
            sel_q       <= '0;
            data_q      <= '0;
            update_pc_q <= 1'b0;
            next_pc_q   <= RESET_PC;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            vld_q       <= vld_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            update_pc_q <= update_pc_d;
            next_pc_q   <= next_pc_d;
        end
    end

    for (genvar b = 0; b < NUM_BYPASS; b++) begin : g_byp
        wb_bypass_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_match (
            .vld      (vld_q),
            .sel      (sel_q),
            .data     (data_q),
            .head     (head_q),
            .lookup   (wb.bypass_sel[b*5 +: 5]),
            .hit      (wb.bypass_hit[b]),
            .hit_data (wb.bypass_data[b*XLEN +: XLEN])
        );
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(rf_valid && $isunknown(wb.rf_write_ready)))
                else $error("rf_write_ready unknown while head valid");
            assert (count_q <= CW'(DEPTH))
                else $error("pending-write count exceeds DEPTH");
        end
    end
`endif
endmodule

// File: tb/tb_writeback_buffered.sv
// Directed bench for writeback_buffered: drain order, backpressure, forwarding, PC priority, reset.
module tb_writeback_buffered;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    writeback_buffered_if #(.XLEN(64), .ALEN(64), .DEPTH(4), .NUM_BYPASS(2)) wbif ();

    writeback_buffered #(.XLEN(64), .ALEN(64), .DEPTH(4), .NUM_BYPASS(2), .RESET_PC('0)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wbif.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic v, input logic w, input logic [4:0] s,
                         input logic [63:0] res, input logic [63:0] nxt);
        wbif.in_valid                   = v;
        wbif.exec_is_reg_write          = w;
        wbif.exec_reg_write_sel         = s;
        wbif.exec_result                = res;
        wbif.exec_instruction_next_addr = nxt;
        wbif.exec_exception             = 1'b0;
        wbif.exec_interrupt             = 1'b0;
        wbif.exec_trap_target           = '0;
        wbif.exec_is_taken_branch       = 1'b0;
        wbif.exec_is_xret               = 1'b0;
        wbif.exec_branch_target         = '0;
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 5'd0, 64'h0, 64'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        wbif.rf_write_ready = 1'b0;
        wbif.bypass_sel     = '0;
        #12;
        chk("rst_count", 64'(wbif.count), 64'd0);
        chk("rst_rfvalid", 64'(wbif.rf_write_valid), 64'd0);
        chk("rst_nextpc", wbif.next_pc, 64'h0);
        chk("rst_updpc", 64'(wbif.update_pc), 64'd0);
        chk("rst_inready", 64'(wbif.in_ready), 64'd1);
        step();
        rst = 1'b0;

        // In-order drain with the regfile always ready
        wbif.rf_write_ready = 1'b1;
        issue(1'b1, 1'b1, 5'd5, 64'h11, 64'h104);
        step();
        chk("t1_count_a", 64'(wbif.count), 64'd1);
        chk("t1_sel_a", 64'(wbif.rf_write_sel), 64'd5);
        chk("t1_data_a", wbif.rf_write_data, 64'h11);
        chk("t1_upd_a", 64'(wbif.update_pc), 64'd1);
        chk("t1_pc_a", wbif.next_pc, 64'h104);
        issue(1'b1, 1'b1, 5'd6, 64'h22, 64'h108);
        step();
        chk("t1_count_b", 64'(wbif.count), 64'd1);
        chk("t1_sel_b", 64'(wbif.rf_write_sel), 64'd6);
        chk("t1_data_b", wbif.rf_write_data, 64'h22);
        chk("t1_pc_b", wbif.next_pc, 64'h108);
        issue(1'b1, 1'b1, 5'd7, 64'h33, 64'h10c);
        step();
        chk("t1_sel_c", 64'(wbif.rf_write_sel), 64'd7);
        chk("t1_data_c", wbif.rf_write_data, 64'h33);
        idle();
        step();
        chk("t1_count_end", 64'(wbif.count), 64'd0);
        chk("t1_upd_end", 64'(wbif.update_pc), 64'd0);
        chk("t1_rfvalid_end", 64'(wbif.rf_write_valid), 64'd0);
        chk("t1_pc_hold", wbif.next_pc, 64'h10c);

        // Backpressure: fill, hold the 5th, then drain one per cycle
        wbif.rf_write_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            issue(1'b1, 1'b1, 5'(i), 64'(i), 64'h200 + 64'(4 * i));
            step();
        end
        chk("t2_count_full", 64'(wbif.count), 64'd4);
        chk("t2_inready_full", 64'(wbif.in_ready), 64'd0);
        issue(1'b1, 1'b1, 5'd5, 64'h5, 64'h214);
        step();
        chk("t2_count_held", 64'(wbif.count), 64'd4);
        chk("t2_head_held", 64'(wbif.rf_write_sel), 64'd1);
        chk("t2_pc_held", wbif.next_pc, 64'h210);
        wbif.rf_write_ready = 1'b1;
        #1;
        chk("t2_inready_deq_full", 64'(wbif.in_ready), 64'd0);
        step();
        chk("t2_count_3", 64'(wbif.count), 64'd3);
        chk("t2_inready_3", 64'(wbif.in_ready), 64'd1);
        chk("t2_head_2", 64'(wbif.rf_write_sel), 64'd2);
        step();
        chk("t2_count_enqdeq", 64'(wbif.count), 64'd3);
        chk("t2_head_3", 64'(wbif.rf_write_sel), 64'd3);
        chk("t2_pc_5th", wbif.next_pc, 64'h214);
        idle();
        step();
        chk("t2_head_4", 64'(wbif.rf_write_sel), 64'd4);
        step();
        chk("t2_head_5", 64'(wbif.rf_write_sel), 64'd5);
        chk("t2_data_5", wbif.rf_write_data, 64'h5);
        step();
        chk("t2_count_0", 64'(wbif.count), 64'd0);

        // Forwarding: youngest match wins, enqueueing entry invisible, dequeueing visible
        wbif.rf_write_ready = 1'b0;
        issue(1'b1, 1'b1, 5'd5, 64'hA, 64'h300);
        step();
        issue(1'b1, 1'b1, 5'd5, 64'hB, 64'h304);
        step();
        idle();
        wbif.bypass_sel = {5'd0, 5'd5};
        #1;
        chk("t3_hit", 64'(wbif.bypass_hit), 64'h1);
        chk("t3_data0", wbif.bypass_data[63:0], 64'hB);
        chk("t3_data1", wbif.bypass_data[127:64], 64'h0);
        wbif.bypass_sel = {5'd7, 5'd5};
        issue(1'b1, 1'b1, 5'd7, 64'hC, 64'h308);
        #1;
        chk("t3_enq_invisible", 64'(wbif.bypass_hit), 64'h1);
        step();
        idle();
        chk("t3_hit_both", 64'(wbif.bypass_hit), 64'h3);
        chk("t3_data1_c", wbif.bypass_data[127:64], 64'hC);
        wbif.rf_write_ready = 1'b1;
        #1;
        chk("t3_deq_visible", wbif.bypass_data[63:0], 64'hB);
        step();
        chk("t3_after_deq_a", wbif.bypass_data[63:0], 64'hB);
        step();
        chk("t3_after_deq_b_hit", 64'(wbif.bypass_hit), 64'h2);
        chk("t3_after_deq_b_data", wbif.bypass_data[63:0], 64'h0);
        step();
        chk("t3_empty_hit", 64'(wbif.bypass_hit), 64'h0);
        wbif.rf_write_ready = 1'b0;
        wbif.bypass_sel = '0;

        // Trap priority and exception write suppression
        issue(1'b1, 1'b1, 5'd9, 64'h99, 64'h400);
        wbif.exec_exception   = 1'b1;
        wbif.exec_trap_target = 64'h80;
        step();
        idle();
        chk("t4_exc_count", 64'(wbif.count), 64'd0);
        chk("t4_exc_pc", wbif.next_pc, 64'h80);
        chk("t4_exc_upd", 64'(wbif.update_pc), 64'd1);
        issue(1'b1, 1'b1, 5'd9, 64'h99, 64'h404);
        wbif.exec_interrupt   = 1'b1;
        wbif.exec_trap_target = 64'h88;
        step();
        idle();
        chk("t4_int_count", 64'(wbif.count), 64'd1);
        chk("t4_int_sel", 64'(wbif.rf_write_sel), 64'd9);
        chk("t4_int_data", wbif.rf_write_data, 64'h99);
        chk("t4_int_pc", wbif.next_pc, 64'h88);
        step();
        chk("t4_upd_low", 64'(wbif.update_pc), 64'd0);
        chk("t4_pc_hold", wbif.next_pc, 64'h88);

        // xRET over taken branch, sequential, branch, x0 write
        issue(1'b1, 1'b0, 5'd0, 64'h1234, 64'h500);
        wbif.exec_is_xret         = 1'b1;
        wbif.exec_is_taken_branch = 1'b1;
        wbif.exec_branch_target   = 64'h600;
        step();
        idle();
        chk("t5_xret_pc", wbif.next_pc, 64'h1234);
        issue(1'b1, 1'b0, 5'd0, 64'h0, 64'h104);
        step();
        idle();
        chk("t5_seq_pc", wbif.next_pc, 64'h104);
        issue(1'b1, 1'b0, 5'd0, 64'h0, 64'h108);
        wbif.exec_is_taken_branch = 1'b1;
        wbif.exec_branch_target   = 64'h700;
        step();
        idle();
        chk("t5_br_pc", wbif.next_pc, 64'h700);
        issue(1'b1, 1'b1, 5'd0, 64'h55, 64'h10c);
        step();
        idle();
        chk("t5_x0_count", 64'(wbif.count), 64'd1);
        chk("t5_x0_pc", wbif.next_pc, 64'h10c);

        // Asynchronous reset with pending writes
        issue(1'b1, 1'b1, 5'd10, 64'h1010, 64'h110);
        step();
        issue(1'b1, 1'b1, 5'd11, 64'h1111, 64'h114);
        step();
        idle();
        wbif.bypass_sel = {5'd0, 5'd10};
        #1;
        chk("t6_count_3", 64'(wbif.count), 64'd3);
        chk("t6_hit_pre", 64'(wbif.bypass_hit), 64'h1);
        chk("t6_upd_pre", 64'(wbif.update_pc), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_count", 64'(wbif.count), 64'd0);
        chk("t6_rst_rfvalid", 64'(wbif.rf_write_valid), 64'd0);
        chk("t6_rst_pc", wbif.next_pc, 64'h0);
        chk("t6_rst_upd", 64'(wbif.update_pc), 64'd0);
        chk("t6_rst_hit", 64'(wbif.bypass_hit), 64'h0);
        chk("t6_rst_inready", 64'(wbif.in_ready), 64'd1);
        step();
        rst = 1'b0;
        step();
        chk("t6_post_count", 64'(wbif.count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
